// File: rtl/bcd_counter_7seg_scan.sv
// Multi-digit BCD up/down counter with synchronous load, wrap carry and a
// time-multiplexed active-low 7-segment driver. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_counter_7seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int CW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Ripple a carry/borrow from digit 0 upward; a chain that survives past
    // the top digit is the wrap, which becomes the carry pulse.
    always_comb begin
        logic       chain;
        logic [3:0] nib;
        count_d = count_q;
        carry_d = 1'b0;
        chain   = 1'b1;
        nib     = 4'd0;
        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                nib = load_val[4*k +: 4];
                count_d[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                nib = count_q[4*k +: 4];
                if (chain) begin
                    if (up_dn) begin
                        if (nib == 4'd9) nib = 4'd0;
                        else begin
                            nib   = nib + 4'd1;
                            chain = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) nib = 4'd9;
                        else begin
                            nib   = nib - 4'd1;
                            chain = 1'b0;
                        end
                    end
                end
                count_d[4*k +: 4] = nib;
            end
            carry_d = chain;
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Display registers sample the current index and count, so the pins
    // trail the counter state by exactly one clock.
    always_comb begin
        logic [3:0] cur;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead_zero;
        lead_zero = 1'b1;
`endif
        cur = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) cur = count_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (k >= int'(idx_q) && count_q[4*k +: 4] != 4'd0) lead_zero = 1'b0;
`endif
        end
        seg_d = decode(cur);
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_zero && idx_q != '0) seg_d = 7'h7F;
`endif
        dig_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= '1;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign count   = count_q;
    assign carry   = carry_q;
    assign seg_out = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: tb/tb_bcd_counter_7seg_scan.sv
// Bench for bcd_counter_7seg_scan (DIGITS=4, SCAN_DIV=4): vector table, reset and
// scan sequences, and random traffic against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_counter_7seg_scan;

    localparam int D    = 4;
    localparam int SD   = 4;
    localparam int MAXV = 9999;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic            en = 1'b0;
    logic            up_dn = 1'b0;
    logic            load = 1'b0;
    logic [4*D-1:0]  load_val = '0;
    logic [4*D-1:0]  count;
    logic            carry;
    logic [6:0]      seg_out;
    logic [D-1:0]    dig_sel;

    int checks = 0;
    int errors = 0;

    // Reference model state: count as a plain decimal integer.
    int   m_val   = 0;
    bit   m_carry = 1'b0;
    int   m_edges = 0;
    logic [6:0] seg_tab [10];

    bcd_counter_7seg_scan #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .seg_out  (seg_out),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int r = 0;
        int n;
        for (int k = 0; k < D; k++) begin
            n = int'(lv[4*k +: 4]);
            if (n > 9) n = 9;
            r = r + n * pow10(k);
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (v / pow10(k)) == 0) return 7'h7F;
`endif
        return seg_tab[(v / pow10(k)) % 10];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val   = 0;
        m_carry = 1'b0;
        m_edges = 0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare every output #1 after the edge.
    task automatic tick();
        int pre_v, pre_i;
        bit l, e, u;
        logic [15:0] lv;
        pre_v = m_val;
        pre_i = (m_edges / SD) % D;
        l = load; e = en; u = up_dn; lv = load_val;
        @(posedge clk);
        #1;
        if (l) begin
            m_val   = clamp_val(lv);
            m_carry = 1'b0;
        end else if (e) begin
            if (u) begin
                m_carry = (m_val == MAXV);
                m_val   = (m_val + 1) % (MAXV + 1);
            end else begin
                m_carry = (m_val == 0);
                m_val   = (m_val == 0) ? MAXV : m_val - 1;
            end
        end else begin
            m_carry = 1'b0;
        end
        m_edges++;
        chk("count",   32'(count),   32'(to_bcd(m_val)));
        chk("carry",   32'(carry),   32'(m_carry));
        chk("dig_sel", 32'(dig_sel), 32'(4'hF ^ (4'h1 << pre_i)));
        chk("seg_out", 32'(seg_out), 32'(exp_seg(pre_v, pre_i)));
    endtask

    task automatic drive(input bit l, input bit e, input bit u, input logic [15:0] lv);
        load = l; en = e; up_dn = u; load_val = lv;
    endtask

    typedef struct {
        bit          ld;
        bit          en;
        bit          up;
        logic [15:0] lv;
        logic [15:0] exp_cnt;
        bit          exp_carry;
    } vec_t;

    vec_t vecs [16];

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vecs[0]  = '{1, 0, 1, 16'h0998, 16'h0998, 0};
        vecs[1]  = '{0, 1, 1, 16'h0000, 16'h0999, 0};
        vecs[2]  = '{0, 1, 1, 16'h0000, 16'h1000, 0};
        vecs[3]  = '{0, 1, 1, 16'h0000, 16'h1001, 0};
        vecs[4]  = '{1, 0, 1, 16'h9999, 16'h9999, 0};
        vecs[5]  = '{0, 1, 1, 16'h0000, 16'h0000, 1};
        vecs[6]  = '{0, 1, 1, 16'h0000, 16'h0001, 0};
        vecs[7]  = '{1, 0, 0, 16'h0000, 16'h0000, 0};
        vecs[8]  = '{0, 1, 0, 16'h0000, 16'h9999, 1};
        vecs[9]  = '{1, 1, 0, 16'h12F4, 16'h1294, 0};
        vecs[10] = '{0, 0, 0, 16'h0000, 16'h1294, 0};
        vecs[11] = '{0, 1, 0, 16'h0000, 16'h1293, 0};
        vecs[12] = '{1, 0, 0, 16'h1000, 16'h1000, 0};
        vecs[13] = '{0, 1, 0, 16'h0000, 16'h0999, 0};
        vecs[14] = '{0, 0, 1, 16'h0000, 16'h0999, 0};
        vecs[15] = '{1, 1, 1, 16'h0F0A, 16'h0909, 0};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   32'(count),   32'h0000);
        chk("rst_carry",   32'(carry),   32'h0);
        chk("rst_seg",     32'(seg_out), 32'h7F);
        chk("rst_dig",     32'(dig_sel), 32'hF);
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        tick();
        chk("first_dig", 32'(dig_sel), 32'hE);
        chk("first_seg", 32'(seg_out), 32'h40);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
        end

        // Reset asserted mid-cycle clears state without a clock edge
        drive(0, 1, 1, 16'h0000);
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count),   32'h0000);
        chk("mid_rst_carry", 32'(carry),   32'h0);
        chk("mid_rst_seg",   32'(seg_out), 32'h7F);
        chk("mid_rst_dig",   32'(dig_sel), 32'hF);
        drive(0, 0, 0, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        model_reset();
        tick();
        chk("rel_dig", 32'(dig_sel), 32'hE);
        chk("rel_seg", 32'(seg_out), 32'h40);

        // Scan sweep over a fixed value, then a leading-zero pattern
        drive(1, 0, 0, 16'h1234);
        tick();
        drive(0, 0, 0, 16'h0000);
        for (int i = 0; i < 4 * SD * D; i++) tick();
        drive(1, 0, 0, 16'h0050);
        tick();
        drive(0, 0, 0, 16'h0000);
        for (int i = 0; i < 2 * SD * D; i++) tick();

        // Random traffic, biased to hit both wrap points
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [15:0] lv;
            r = $urandom_range(0, 99);
            if (r < 3)      lv = 16'h9999;
            else if (r < 6) lv = 16'h0000;
            else            lv = 16'($urandom);
            drive(r < 10, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, lv);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_7seg_scan.md
Name: bcd_counter_7seg_scan

Overview:
- Parametrised multi-digit BCD up/down counter with synchronous load and wrap carry.
- Drives a time-multiplexed 7-segment display: one shared segment bus plus one-hot digit selects.
- Generalises the single-digit 4-bit up counter with 7-segment output to N digits, both count directions, preset load and display scanning.
- Sits between board-level tick/button logic and the display pins.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
- SCAN_DIV, 1024, clk cycles each digit is shown before the scan advances (>=2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- en  in  1  count enable, sampled each clk; one step per high cycle.
- up_dn  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load of load_val; priority over en.
- load_val  in  4*DIGITS  BCD preset; nibble k is digit k, nibble 0 is least significant.
- count  out  4*DIGITS  registered BCD count value.
- carry  out  1  one-cycle wrap pulse.
- seg_out  out  7  active-low segments {g,f,e,d,c,b,a}.
- dig_sel  out  DIGITS  active-low one-hot digit enable; bit k selects digit k.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - count=0, carry=0.
  - Scan counter=0, digit index=0.
  - seg_out=7'h7F (all segments off), dig_sel=all ones (all digits off).
- Priority on each clk edge: load > en > hold.
- load=1: count <= load_val. Any nibble >9 is clamped to 9. carry <= 0.
- en=1, up_dn=1: BCD increment. Digit k rolls 9->0 and increments digit k+1 only when all lower digits are 9.
- en=1, up_dn=0: BCD decrement. Digit k rolls 0->9 and borrows from digit k+1 only when all lower digits are 0.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - carry=1 for exactly the cycle in which count shows the wrapped value. Otherwise carry=0.
- en=0 and load=0: count holds, carry=0.
- Scan:
  - Free-running counter from 0 to SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and the digit index advances, wrapping DIGITS-1 -> 0.
  - Scanning ignores en, load and up_dn.
- Display outputs (registered, updated together every cycle):
  - dig_sel = ~(1 << index).
  - seg_out = decode(current count nibble[index]), so count changes appear within 1 clk.
  - First edge after reset release: dig_sel bit 0 low, seg_out shows digit 0.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 are unreachable; if present, output blank 7F.
- Reset asserted mid-operation: all state clears immediately, with no dependence on clk.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digit k>0 is shown blank (seg_out=7'h7F, dig_sel still driven) when it and every more significant digit are 0. Digit 0 is never blanked.
- Undefined: all digits are always displayed, including leading zeros.
- count and carry are identical in both builds.

Test Plan (DIGITS=4, SCAN_DIV=4):
1. Reset: hold clr_n=0 mid-cycle -> count=16'h0000, carry=0, seg_out=7'h7F, dig_sel=4'hF immediately. Release -> next edge dig_sel=4'hE, seg_out=7'h40.
2. Up count: load 16'h0998, then en=1, up_dn=1 for 3 cycles -> count 0999, 1000, 1001; carry stays 0.
3. Up wrap: load 16'h9999, en=1, up_dn=1 -> count=0000 with carry=1 for one cycle; next cycle count=0001, carry=0.
4. Down wrap with priority: at count=0000 apply en=1, up_dn=0 -> count=9999, carry=1. Then load=1 with en=1 and load_val=16'h12F4 -> count=12 9 4 (clamped, 16'h1294), carry=0.
5. Scan: count=16'h1234 -> dig_sel steps E,D,B,7,E every 4 clks, with seg_out 19,30,24,79 in step. With LEADING_ZERO_BLANK_EN and count=16'h0050, digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40.
